// File: rtl/ag32gbd_pkg.sv
// Shared types and constants for the ag32gbd frame packer: 2bpp shade codes,
// packer states, the 4x4 Bayer table and the quantise/dither helpers.
package ag32gbd_pkg;

  localparam int OFF_W           = 10;
  localparam int DEF_FRAME_BYTES = 256;
  localparam int ENTRY_W         = OFF_W + 8;

  typedef enum logic [1:0] {
    SHADE_WHITE = 2'd0,
    SHADE_LIGHT = 2'd1,
    SHADE_DARK  = 2'd2,
    SHADE_BLACK = 2'd3
  } shade_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN,
    ST_SWAP_WAIT
  } state_e;

  // Row-major, index = (line%4)*4 + (col%4).
  localparam logic [3:0] BAYER [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  function automatic shade_e quantise(input logic [7:0] v, input logic [7:0] t0,
                                      input logic [7:0] t1, input logic [7:0] t2);
    if (v < t0)      return SHADE_BLACK;
    else if (v < t1) return SHADE_DARK;
    else if (v < t2) return SHADE_LIGHT;
    else             return SHADE_WHITE;
  endfunction

  function automatic logic [7:0] sat8_dither(input logic [7:0] v, input logic [3:0] b);
    logic signed [9:0] s;
    s = $signed({2'b00, v}) + $signed({6'b000000, b}) - 10'sd8;
    if (s[9])             return 8'h00;
    else if (s > 10'sd255) return 8'hFF;
    else                  return s[7:0];
  endfunction

endpackage

// File: rtl/ag32gbd_frame_packer_wr_fifo.sv
// ag32gbd_wr_fifo: 2-entry FIFO of {offset, data} between the pixel packer and
// the registered buffer-write port. A push into a full FIFO is ignored.
module ag32gbd_wr_fifo
  import ag32gbd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] din_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] dout_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [ENTRY_W-1:0] mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '{default: '0};
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush_i) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) rptr_q <= ~rptr_q;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/ag32gbd_frame_packer.sv
// 8-bit luminance -> 2bpp packer feeding the BRAM controller's buffer-write port.
// Optional ordered dither before quantisation: define AG32GBD_PACKER_DITHER_EN.
module ag32gbd_frame_packer
  import ag32gbd_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int LINE_PIXELS = 32,
  parameter int FLIP_GUARD  = 10
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             FrameStart,
  input  logic             PixelValid,
  input  logic [7:0]       PixelData,
  input  logic [7:0]       Thresh0,
  input  logic [7:0]       Thresh1,
  input  logic [7:0]       Thresh2,
  input  logic             PortABusy,
  output logic             RequestWriteBuffer,
  output logic [7:0]       BufferWriteData,
  output logic [OFF_W-1:0] BufferWriteOffset,
  output logic             FlipBuffer,
  output logic             FrameDone,
  output logic             Overflow,
  output logic             Busy
);

  localparam int GW = $clog2(FLIP_GUARD + 1);

  state_e             state_q;
  logic [1:0]         phase_q;
  logic [5:0]         sh_q;
  logic [OFF_W-1:0]   pack_off_q;
  logic [GW-1:0]      guard_q;
  logic               req_q, flip_q, done_q, ovf_q;
  logic [7:0]         data_q;
  logic [OFF_W-1:0]   woff_q;

  logic [7:0]         pix_v;
  logic [1:0]         code;
  logic [7:0]         byte_d;
  logic               accept, byte_done, last_byte, abort, load;
  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_dout;

  // A pixel coinciding with FrameStart is always discarded.
  assign accept    = (state_q == ST_CAPTURE) && PixelValid && !FrameStart;
  assign byte_done = accept && (phase_q == 2'd3);
  assign last_byte = byte_done && (pack_off_q == OFF_W'(FRAME_BYTES - 1));
  assign abort     = FrameStart && ((state_q == ST_CAPTURE) || (state_q == ST_DRAIN));
  assign load      = !fifo_empty && (guard_q == '0) && (!req_q || !PortABusy) && !abort;

`ifdef AG32GBD_PACKER_DITHER_EN
  localparam int CW = $clog2(LINE_PIXELS);
  logic [CW-1:0] col_q;
  logic [1:0]    line_q;

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      line_q <= 2'd0;
    end else if (FrameStart) begin
      col_q  <= '0;
      line_q <= 2'd0;
    end else if (accept) begin
      if (col_q == CW'(LINE_PIXELS - 1)) begin
        col_q  <= '0;
        line_q <= line_q + 2'd1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  assign pix_v = sat8_dither(PixelData, BAYER[{line_q, col_q[1:0]}]);
`else
  assign pix_v = PixelData;
`endif

  // Bayer indexing assumes lines hold whole 4-pixel dither columns.
  if (LINE_PIXELS % 4 != 0) begin : g_line_pixels_not_mult4
  end

  assign code   = quantise(pix_v, Thresh0, Thresh1, Thresh2);
  assign byte_d = {sh_q, code};

  ag32gbd_wr_fifo u_fifo (
    .clk     (sys_clock),
    .rst     (reset),
    .flush_i (abort),
    .push_i  (byte_done),
    .din_i   ({pack_off_q, byte_d}),
    .pop_i   (load),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= 2'd0;
      sh_q       <= 6'd0;
      pack_off_q <= '0;
      guard_q    <= '0;
      req_q      <= 1'b0;
      data_q     <= 8'd0;
      woff_q     <= '0;
      flip_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (guard_q != '0) guard_q <= guard_q - 1'b1;

      if (req_q && !PortABusy) req_q <= 1'b0;
      if (load) begin
        req_q  <= 1'b1;
        data_q <= fifo_dout[7:0];
        woff_q <= fifo_dout[ENTRY_W-1:8];
      end

      if (accept) begin
        phase_q <= phase_q + 2'd1;
        sh_q    <= {sh_q[3:0], code};
        // A dropped byte still consumes its offset so later bytes land in place.
        if (byte_done) begin
          if (fifo_full) ovf_q <= 1'b1;
          pack_off_q <= last_byte ? '0 : pack_off_q + 1'b1;
        end
      end

      if (FrameStart) begin
        state_q    <= ST_CAPTURE;
        phase_q    <= 2'd0;
        pack_off_q <= '0;
        ovf_q      <= 1'b0;
        if (abort) req_q <= 1'b0;
      end else begin
        case (state_q)
          ST_CAPTURE: if (last_byte) state_q <= ST_DRAIN;
          ST_DRAIN: begin
            if (fifo_empty && !req_q) begin
              flip_q  <= ~flip_q;
              done_q  <= 1'b1;
              guard_q <= GW'(FLIP_GUARD);
              state_q <= ST_SWAP_WAIT;
            end
          end
          ST_SWAP_WAIT: if (guard_q <= GW'(1)) state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign RequestWriteBuffer = req_q;
  assign BufferWriteData    = data_q;
  assign BufferWriteOffset  = woff_q;
  assign FlipBuffer         = flip_q;
  assign FrameDone          = done_q;
  assign Overflow           = ovf_q;
  assign Busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ag32gbd_frame_packer.sv
// Scoreboard bench for ag32gbd_frame_packer: stimulus pushes expected {offset, byte}
// per completed group of four pixels; a negedge monitor checks every consumed write.
module tb_ag32gbd_frame_packer;

  localparam int FB   = 256;
  localparam int NPIX = FB * 4;

  logic       sys_clock = 1'b0;
  logic       reset = 1'b1;
  logic       FrameStart = 1'b0, PixelValid = 1'b0, PortABusy = 1'b0;
  logic [7:0] PixelData = 8'd0, Thresh0 = 8'd0, Thresh1 = 8'd0, Thresh2 = 8'd0;
  logic       RequestWriteBuffer, FlipBuffer, FrameDone, Overflow, Busy;
  logic [7:0] BufferWriteData;
  logic [9:0] BufferWriteOffset;

  int n_chk = 0, n_fail = 0;

  typedef struct {int off; int data;} exp_t;
  exp_t exp_q[$];
  int         mdl_k = 0;
  logic [7:0] mdl_acc = 8'd0;
  bit         exp_flip = 1'b0, done_seen = 1'b0, hold_pend = 1'b0;
  int         guard_cnt = 0;
  logic [7:0] hold_d;
  logic [9:0] hold_o;

  always #5 sys_clock = ~sys_clock;

  ag32gbd_frame_packer dut (
    .sys_clock          (sys_clock),
    .reset              (reset),
    .FrameStart         (FrameStart),
    .PixelValid         (PixelValid),
    .PixelData          (PixelData),
    .Thresh0            (Thresh0),
    .Thresh1            (Thresh1),
    .Thresh2            (Thresh2),
    .PortABusy          (PortABusy),
    .RequestWriteBuffer (RequestWriteBuffer),
    .BufferWriteData    (BufferWriteData),
    .BufferWriteOffset  (BufferWriteOffset),
    .FlipBuffer         (FlipBuffer),
    .FrameDone          (FrameDone),
    .Overflow           (Overflow),
    .Busy               (Busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pixel index within the frame gives dither position and byte slot.
  function automatic int dith(input int v);
    int r = v;
`ifdef AG32GBD_PACKER_DITHER_EN
    int bt[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
    r = v + bt[((mdl_k / 32) % 4) * 4 + (mdl_k % 4)] - 8;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
`endif
    return r;
  endfunction

  function automatic logic [1:0] shade(input int v);
    if (v < int'(Thresh0)) return 2'd3;
    if (v < int'(Thresh1)) return 2'd2;
    if (v < int'(Thresh2)) return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_pixel(input int v);
    if (mdl_k < NPIX) begin
      mdl_acc = {mdl_acc[5:0], shade(dith(v))};
      mdl_k++;
      if (mdl_k % 4 == 0) exp_q.push_back('{mdl_k / 4 - 1, int'(mdl_acc)});
    end
  endtask

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic pix(input int v);
    PixelValid = 1'b1;
    PixelData  = 8'(v);
    model_pixel(v);
    tick();
    PixelValid = 1'b0;
  endtask

  task automatic start(input bit with_pix);
    FrameStart = 1'b1;
    PixelValid = with_pix;
    PixelData  = 8'($urandom_range(0, 255));
    tick();
    FrameStart = 1'b0;
    PixelValid = 1'b0;
    exp_q.delete();
    mdl_k = 0;
  endtask

  task automatic run(input int n, input bit gaps, input bit rbusy);
    for (int i = 0; i < n; i++) begin
      PortABusy = rbusy ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) tick();
      pix($urandom_range(0, 255));
    end
    PortABusy = 1'b0;
  endtask

  task automatic rand_thresh();
    int a, b, c, t;
    a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 255);
    if (a > b) begin t = a; a = b; b = t; end
    if (b > c) begin t = b; b = c; c = t; end
    if (a > b) begin t = a; a = b; b = t; end
    Thresh0 = 8'(a); Thresh1 = 8'(b); Thresh2 = 8'(c);
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (!done_seen && i < 3000) begin
      tick();
      i++;
    end
    check({name, "_done"}, int'(done_seen), 1);
    done_seen = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int i = 0;
    while (!RequestWriteBuffer && i < 40) begin
      tick();
      i++;
    end
    check({name, "_req"}, int'(RequestWriteBuffer), 1);
  endtask

  task automatic check_zero(input string name);
    check({name, "_req"},  int'(RequestWriteBuffer), 0);
    check({name, "_data"}, int'(BufferWriteData), 0);
    check({name, "_off"},  int'(BufferWriteOffset), 0);
    check({name, "_flip"}, int'(FlipBuffer), 0);
    check({name, "_done"}, int'(FrameDone), 0);
    check({name, "_ovf"},  int'(Overflow), 0);
    check({name, "_busy"}, int'(Busy), 0);
  endtask

  // Monitor: write consumption, hold stability, flip guard and frame completion.
  always @(negedge sys_clock) begin
    if (reset) begin
      hold_pend = 1'b0;
      guard_cnt = 0;
    end else begin
      if (hold_pend) begin
        check("hold_req",  int'(RequestWriteBuffer), 1);
        check("hold_data", int'(BufferWriteData), int'(hold_d));
        check("hold_off",  int'(BufferWriteOffset), int'(hold_o));
      end
      hold_pend = RequestWriteBuffer && PortABusy && !FrameStart;
      hold_d    = BufferWriteData;
      hold_o    = BufferWriteOffset;

      if (guard_cnt > 0) begin
        check("guard_no_req", int'(RequestWriteBuffer), 0);
        guard_cnt--;
      end

      if (RequestWriteBuffer && !PortABusy) begin
        // Dropped bytes leave gaps, legal only once Overflow is flagged.
        while (exp_q.size() > 0 && exp_q[0].off != int'(BufferWriteOffset) && Overflow)
          void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          check("write_unexpected_off", int'(BufferWriteOffset), -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_off",  int'(BufferWriteOffset), e.off);
          check("write_data", int'(BufferWriteData), e.data);
        end
      end

      if (FrameDone) begin
        exp_flip = ~exp_flip;
        check("frame_flip", int'(FlipBuffer), int'(exp_flip));
        check("frame_pixels", mdl_k, NPIX);
        check("frame_drained", (exp_q.size() == 0 || Overflow) ? 1 : 0, 1);
        exp_q.delete();
        guard_cnt = 10;
        done_seen = 1'b1;
      end
    end
  end

  initial begin
    #12;
    check_zero("reset");
    @(negedge sys_clock);
    reset = 1'b0;
    tick();

    // Frame 1: fixed pattern, 2-cycle latency, then random pixels with gaps.
    Thresh0 = 8'd64; Thresh1 = 8'd128; Thresh2 = 8'd192;
    start(1'b0);
    pix(10); pix(100); pix(150); pix(250);
    check("lat_cycle1_req", int'(RequestWriteBuffer), 0);
    tick();
    check("lat_cycle2_req",  int'(RequestWriteBuffer), 1);
    check("lat_cycle2_data", int'(BufferWriteData), 8'hE4);
    check("lat_cycle2_off",  int'(BufferWriteOffset), 0);
    run(NPIX - 4, 1'b1, 1'b0);
    pix(0); pix(0);                         // beyond the frame: ignored
    wait_done("f1");

    // Frame 2: back-to-back, all white.
    start(1'b0);
    for (int i = 0; i < NPIX; i++) pix(255);
    wait_done("f2");
    check("f2_flip_back", int'(FlipBuffer), 0);

    // Frame 3: hold a pending write for 5 cycles, then force overflow.
    rand_thresh();
    start(1'b0);
    for (int i = 0; i < 4; i++) pix($urandom_range(0, 255));
    wait_req("f3_hold");
    PortABusy = 1'b1;
    repeat (5) tick();
    PortABusy = 1'b0;
    check("f3_consume_req", int'(RequestWriteBuffer), 1);
    check("f3_consume_off", int'(BufferWriteOffset), 0);
    tick();
    PortABusy = 1'b1;
    for (int i = 0; i < 48; i++) pix($urandom_range(0, 255));
    check("f3_overflow", int'(Overflow), 1);
    PortABusy = 1'b0;
    run(NPIX - 52, 1'b0, 1'b1);
    wait_done("f3");

    // Frame 4: abort after byte 37 with a byte still queued.
    rand_thresh();
    start(1'b0);
    check("f4_ovf_cleared", int'(Overflow), 0);
    run(148, 1'b0, 1'b0);
    PortABusy = 1'b1;
    for (int i = 0; i < 7; i++) pix($urandom_range(0, 255));
    PortABusy = 1'b0;
    start(1'b1);                            // FrameStart wins over the 4th pixel
    repeat (4) tick();
    check("abort_no_done", int'(done_seen), 0);
    check("abort_flip", int'(FlipBuffer), int'(exp_flip));
    check("abort_no_req", int'(RequestWriteBuffer), 0);
    for (int i = 0; i < 4; i++) pix($urandom_range(0, 255));
    tick();
    check("abort_next_req", int'(RequestWriteBuffer), 1);
    check("abort_next_off", int'(BufferWriteOffset), 0);

    // Asynchronous reset while a write is presented.
    #1 reset = 1'b1;
    #1 check_zero("async_reset");
    exp_flip = 1'b0;
    exp_q.delete();
    @(negedge sys_clock);
    reset = 1'b0;
    tick();
    check("post_reset_busy", int'(Busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
